// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and fetch-stage constants.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
  localparam word_t PC_STEP         = 32'h0000_0004;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the icache and feeds the IF/ID latch,
// handling stalls, redirects (including during an outstanding miss) and halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t ifid_imemload,
  output word_t ifid_pcp4,
  output logic  ifid_enable,
  output logic  ifid_flush,
  output logic  halted
);

  fetch_state_t r_state, w_state_nxt;
  word_t        r_pc, w_pc_nxt;
  word_t        r_pending_pc, w_pending_nxt;
  word_t        w_redirect_tgt;
  word_t        w_pcp4;
  logic         w_enable, w_flush;
  logic         w_unused_bits;

  assign w_redirect_tgt = {redirect_pc[WORD_W-1:2], 2'b00};
  assign w_unused_bits  = ^redirect_pc[1:0];
  assign w_pcp4         = r_pc + PC_STEP;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= FETCH;
      r_pc         <= PC_INIT;
      r_pending_pc <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
    end
  end

  // Priority: halt > redirect > stall > ihit advance.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending_pc;
    w_enable      = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      FETCH: begin
        if (halt) begin
          w_state_nxt = HALTED;
          w_flush     = 1'b1;
        end else if (redirect) begin
          w_flush = 1'b1;
          if (ihit) begin
            w_pc_nxt = w_redirect_tgt;
          end else begin
            // Keep the old address on the bus until the in-flight miss returns.
            w_pending_nxt = w_redirect_tgt;
            w_state_nxt   = DRAIN;
          end
        end else if (!stall && ihit) begin
          w_pc_nxt = w_pcp4;
          w_enable = 1'b1;
        end
      end
      DRAIN: begin
        w_flush = 1'b1;
        if (ihit) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = redirect ? w_redirect_tgt : r_pending_pc;
        end else if (redirect) begin
          w_pending_nxt = w_redirect_tgt;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imemREN       = (r_state != HALTED);
  assign halted        = (r_state == HALTED);
  assign imemaddr      = {r_pc[WORD_W-1:2], 2'b00};
  assign ifid_imemload = imemload;
  assign ifid_pcp4     = w_pcp4;
  // Latch controls stay quiet while reset is held, whatever the cache reports.
  assign ifid_enable   = nRST & w_enable;
  assign ifid_flush    = nRST & w_flush;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit (PC_INIT = 0 and PC_INIT = 0xFFFF_FFFC instances).
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST, ihit, stall, redirect, halt;
  word_t imemload, redirect_pc;

  logic  a_ren, a_en, a_fl, a_hlt;
  word_t a_addr, a_ld, a_pcp4;
  logic  b_ren, b_en, b_fl, b_hlt;
  word_t b_addr, b_ld, b_pcp4;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000)) u_dut_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(a_ren), .imemaddr(a_addr), .ifid_imemload(a_ld), .ifid_pcp4(a_pcp4),
    .ifid_enable(a_en), .ifid_flush(a_fl), .halted(a_hlt)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(b_ren), .imemaddr(b_addr), .ifid_imemload(b_ld), .ifid_pcp4(b_pcp4),
    .ifid_enable(b_en), .ifid_flush(b_fl), .halted(b_hlt)
  );

  typedef struct {
    string tag;
    logic  sel_b;
    word_t addr;
    word_t pcp4;
    word_t ld;
    logic  en;
    logic  fl;
    logic  ren;
    logic  hlt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string tag, input string field, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // Pop every pending expectation and compare against the selected instance.
  task automatic drain_sb;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel_b) begin
        cmp(e.tag, "imemaddr", b_addr, e.addr);
        cmp(e.tag, "pcp4", b_pcp4, e.pcp4);
        cmp(e.tag, "imemload", b_ld, e.ld);
        cmp(e.tag, "enable", 32'(b_en), 32'(e.en));
        cmp(e.tag, "flush", 32'(b_fl), 32'(e.fl));
        cmp(e.tag, "imemREN", 32'(b_ren), 32'(e.ren));
        cmp(e.tag, "halted", 32'(b_hlt), 32'(e.hlt));
      end else begin
        cmp(e.tag, "imemaddr", a_addr, e.addr);
        cmp(e.tag, "pcp4", a_pcp4, e.pcp4);
        cmp(e.tag, "imemload", a_ld, e.ld);
        cmp(e.tag, "enable", 32'(a_en), 32'(e.en));
        cmp(e.tag, "flush", 32'(a_fl), 32'(e.fl));
        cmp(e.tag, "imemREN", 32'(a_ren), 32'(e.ren));
        cmp(e.tag, "halted", 32'(a_hlt), 32'(e.hlt));
      end
    end
  endtask

  task automatic push(input string tag, input logic sel_b, input word_t addr, input word_t pcp4,
                      input logic en, input logic fl, input logic ren, input logic hlt);
    exp_t e;
    e.tag = tag; e.sel_b = sel_b; e.addr = addr; e.pcp4 = pcp4; e.ld = imemload;
    e.en = en; e.fl = fl; e.ren = ren; e.hlt = hlt;
    sb.push_back(e);
  endtask

  // Drive one cycle's inputs at the falling edge; check before the next rising edge.
  task automatic step(input string tag, input logic i_hit, input logic i_stall, input logic i_redir,
                      input word_t i_rpc, input logic i_halt, input logic sel_b,
                      input word_t addr, input word_t pcp4, input logic en, input logic fl,
                      input logic ren, input logic hlt);
    @(negedge CLK);
    ihit = i_hit; stall = i_stall; redirect = i_redir; redirect_pc = i_rpc; halt = i_halt;
    imemload = $urandom;
    push(tag, sel_b, addr, pcp4, en, fl, ren, hlt);
    #1;
    drain_sb();
  endtask

  // Asynchronous reset mid-cycle with ihit high; both instances must show reset outputs.
  task automatic do_reset(input string tag);
    @(posedge CLK);
    #2;
    ihit = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    nRST = 1'b0;
    push({tag, "_a"}, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
    push({tag, "_b"}, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    drain_sb();
    ihit = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirect_pc = '0; imemload = 32'h1234_5678;
    do_reset("reset");

    step("hit0",   1, 0, 0, 32'h0,   0, 0, 32'h00, 32'h04, 1, 0, 1, 0);
    step("hit1",   1, 0, 0, 32'h0,   0, 0, 32'h04, 32'h08, 1, 0, 1, 0);
    step("stall0", 1, 1, 0, 32'h0,   0, 0, 32'h08, 32'h0C, 0, 0, 1, 0);
    step("stall1", 1, 1, 0, 32'h0,   0, 0, 32'h08, 32'h0C, 0, 0, 1, 0);
    step("unstl",  1, 0, 0, 32'h0,   0, 0, 32'h08, 32'h0C, 1, 0, 1, 0);
    step("hit3",   1, 0, 0, 32'h0,   0, 0, 32'h0C, 32'h10, 1, 0, 1, 0);
    step("rmiss",  0, 0, 1, 32'h40,  0, 0, 32'h10, 32'h14, 0, 1, 1, 0);
    step("drain0", 0, 0, 0, 32'h0,   0, 0, 32'h10, 32'h14, 0, 1, 1, 0);
    step("drainr", 0, 0, 1, 32'h80,  0, 0, 32'h10, 32'h14, 0, 1, 1, 0);
    step("drainh", 1, 0, 0, 32'h0,   0, 0, 32'h10, 32'h14, 0, 1, 1, 0);
    step("rhit",   1, 0, 1, 32'h43,  0, 0, 32'h80, 32'h84, 0, 1, 1, 0);
    step("tgt40",  0, 0, 0, 32'h0,   0, 0, 32'h40, 32'h44, 0, 0, 1, 0);
    step("rmiss2", 0, 0, 1, 32'h100, 0, 0, 32'h40, 32'h44, 0, 1, 1, 0);
    step("drnhlt", 1, 0, 1, 32'h200, 1, 0, 32'h40, 32'h44, 0, 1, 1, 0);
    step("haltr",  0, 0, 1, 32'h300, 1, 0, 32'h200, 32'h204, 0, 1, 1, 0);
    step("hlt0",   1, 0, 0, 32'h0,   0, 0, 32'h200, 32'h204, 0, 0, 0, 1);
    step("hlt1",   1, 0, 1, 32'h40,  0, 0, 32'h200, 32'h204, 0, 0, 0, 1);

    do_reset("unhalt");
    step("miss",   0, 0, 1, 32'h40,  0, 0, 32'h00, 32'h04, 0, 1, 1, 0);
    do_reset("midmiss");
    step("restart", 1, 0, 0, 32'h0,  0, 0, 32'h00, 32'h04, 1, 0, 1, 0);
    step("nopend",  0, 0, 0, 32'h0,  0, 0, 32'h04, 32'h08, 0, 0, 1, 0);

    do_reset("wrap");
    step("wrap0",  1, 0, 0, 32'h0,   0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 1, 0);
    step("wrap1",  0, 0, 0, 32'h0,   0, 1, 32'h0000_0000, 32'h0000_0004, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
